// File: rtl/link_cmd_ctl.sv
// ---------------------------------------------------------------------------
// link_cmd_ctl
//
// Command link controller between the game top and the UART transceiver.
//   TX: turns the game's level-style request (game_valid/game_byte) into
//       single, deduplicated UART byte writes through a small queue.
//   RX: turns UART bytes into a command level held on cmd_out for
//       HOLD_CYCLES cycles, then forces 8'h00 for two cycles so that the
//       game's change detector also sees repeated commands.
// Valid command codes: 8'h30 (fire), 8'h31 (water), 8'h32 (game lost).
//
// Parameters:
//   FIFO_DEPTH  - TX queue depth in bytes (power of two, 2..16)
//   HOLD_CYCLES - cycles a received command is held on cmd_out (>= 2)
//
// Ports:
//   clk65MHz   in   system clock
//   rst        in   synchronous active-high reset
//   game_valid in   game data_ready level
//   game_byte  in   game data_out byte
//   cmd_out    out  command level to the game's data_in
//   tx_data    out  byte to the UART TX FIFO
//   tx_wr      out  one-cycle write strobe to the UART TX FIFO
//   tx_full    in   UART TX FIFO full
//   rx_data    in   head of the UART RX FIFO (first-word-fall-through)
//   rx_empty   in   UART RX FIFO empty
//   rx_rd      out  one-cycle pop strobe to the UART RX FIFO
//   tx_drop    out  pulse: a valid TX byte was discarded (queue full)
//   rx_err     out  pulse: a received byte was not a valid command
//
// Build option:
//   LINK_LOOPBACK_EN - the TX queue head feeds the RX state machine instead
//                      of the UART RX FIFO; tx_wr and rx_rd are tied to 0.
// ---------------------------------------------------------------------------
module link_cmd_ctl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk65MHz,
  input  logic       rst,
  input  logic       game_valid,
  input  logic [7:0] game_byte,
  output logic [7:0] cmd_out,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_full,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  output logic       tx_drop,
  output logic       rx_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int HCNT_W = $clog2(HOLD_CYCLES);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_HOLD, S_GAP} rx_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == 8'h30) || (b == 8'h31) || (b == 8'h32);
  endfunction

  // ---------------- TX capture ----------------
  logic       r_prev_valid;
  logic [7:0] r_last_byte;
  logic       w_capture;
  logic       w_push_req;

  // A new level, or a byte change while the level is held, is one event.
  assign w_capture  = game_valid && (!r_prev_valid || (game_byte != r_last_byte));
  assign w_push_req = w_capture && is_cmd(game_byte);

  // ---------------- TX queue ----------------
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_drain;
  logic [7:0]       w_head;
  logic             w_src_empty;
  logic [7:0]       w_src_data;

  logic [7:0] r_tx_data;
  logic       r_tx_wr;
  logic       r_tx_drop;
  logic       r_rx_rd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef LINK_LOOPBACK_EN
  // The RX machine only strobes rx_rd after seeing a non-empty queue.
  assign w_drain     = 1'b0;
  assign w_pop       = r_rx_rd;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_src_empty = w_empty;
  assign w_src_data  = w_head;
  logic w_unused_uart;
  assign w_unused_uart = ^{rx_data, rx_empty, tx_full};
`else
  // An empty queue is bypassed so a capture is written on the very next edge.
  assign w_drain     = !tx_full && !r_tx_wr && (!w_empty || w_push_req);
  assign w_pop       = w_drain;
  assign w_head      = w_empty ? game_byte : r_mem[r_rd_ptr];
  assign w_src_empty = rx_empty;
  assign w_src_data  = rx_data;
`endif

  // A full queue still accepts a byte when its head leaves in the same cycle.
  assign w_push = w_push_req && (!w_full || w_pop);

  // NOTE: queue storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk65MHz) begin
    if (w_push) r_mem[r_wr_ptr] <= game_byte;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_last_byte  <= 8'h00;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_tx_data    <= 8'h00;
      r_tx_wr      <= 1'b0;
      r_tx_drop    <= 1'b0;
    end else begin
      r_prev_valid <= game_valid;
      if (w_capture) r_last_byte <= game_byte;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_tx_wr   <= w_drain;
      if (w_drain) r_tx_data <= w_head;
      r_tx_drop <= w_push_req && !w_push;
    end
  end

  // ---------------- RX state machine ----------------
  rx_state_t         r_state, w_state_nxt;
  logic [7:0]        r_rx_byte, w_rx_byte_nxt;
  logic [7:0]        r_cmd, w_cmd_nxt;
  logic [HCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic              w_rx_rd_nxt;
  logic              r_rx_err, w_rx_err_nxt;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_rx_byte_nxt = r_rx_byte;
    w_cmd_nxt     = r_cmd;
    w_cnt_nxt     = r_cnt;
    w_rx_rd_nxt   = 1'b0;
    w_rx_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_src_empty) begin
          w_rx_byte_nxt = w_src_data;
          w_rx_rd_nxt   = 1'b1;
          w_state_nxt   = S_POP;
        end
      end
      S_POP: begin
        if (is_cmd(r_rx_byte)) begin
          w_cmd_nxt   = r_rx_byte;
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end else begin
          w_rx_err_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_cmd_nxt   = 8'h00;
          w_cnt_nxt   = HCNT_W'(1);
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - HCNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - HCNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rx_byte <= 8'h00;
      r_cmd     <= 8'h00;
      r_cnt     <= '0;
      r_rx_rd   <= 1'b0;
      r_rx_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rx_byte <= w_rx_byte_nxt;
      r_cmd     <= w_cmd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rx_rd   <= w_rx_rd_nxt;
      r_rx_err  <= w_rx_err_nxt;
    end
  end

  // ---------------- outputs ----------------
  assign cmd_out = r_cmd;
  assign tx_data = r_tx_data;
  assign tx_drop = r_tx_drop;
  assign rx_err  = r_rx_err;
`ifdef LINK_LOOPBACK_EN
  assign tx_wr = 1'b0;
  assign rx_rd = 1'b0;
`else
  assign tx_wr = r_tx_wr;
  assign rx_rd = r_rx_rd;
`endif

endmodule

// File: tb/tb_link_cmd_ctl.sv
// ---------------------------------------------------------------------------
// tb_link_cmd_ctl
//
// Self-checking bench for link_cmd_ctl (default UART build). The bench plays
// the game and both UART FIFOs. A behavioural model (a byte queue for TX and
// a timeline of scheduled RX events) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_link_cmd_ctl;
  localparam int DEPTH = 4;
  localparam int HOLD  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_valid;
  logic [7:0] game_byte;
  logic [7:0] cmd_out;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd;
  logic       tx_drop;
  logic       rx_err;

  always #5 clk = ~clk;

  link_cmd_ctl #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk65MHz  (clk),
    .rst       (rst),
    .game_valid(game_valid),
    .game_byte (game_byte),
    .cmd_out   (cmd_out),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_full   (tx_full),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_rd     (rx_rd),
    .tx_drop   (tx_drop),
    .rx_err    (rx_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state
  logic [7:0] tq[$];          // TX queue contents
  logic [7:0] rxq[$];         // UART RX FIFO contents (environment)
  bit         m_prev_v = 0;
  logic [7:0] m_last   = 8'h00;
  bit         e_wr = 0, e_drop = 0, e_rd = 0, e_err = 0;
  logic [7:0] e_data = 8'h00, e_cmd = 8'h00, cmd_b = 8'h00;
  int         idle_from = 0, rd_at = -1, err_at = -1, cmd_from = -1, cmd_to = -2;

  // Observed statistics for directed literal checks
  int         s_wr, s_drop, s_rd, s_err, s_cmd_nz, cmd_first, cmd_last;
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         rd_cyc[$];
  int         err_cyc[$];

  function automatic bit is_cmd(input logic [7:0] b);
    return (b == 8'h30) || (b == 8'h31) || (b == 8'h32);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    s_wr = 0; s_drop = 0; s_rd = 0; s_err = 0; s_cmd_nz = 0;
    cmd_first = -1; cmd_last = -1;
    wr_data.delete(); wr_cyc.delete(); rd_cyc.delete(); err_cyc.delete();
  endtask

  // One clock cycle: predict outputs of the next cycle from this cycle's
  // inputs, advance the clock, then compare every output.
  task automatic step();
    bit         n_wr, n_drop, n_rd, n_err, cap, can;
    logic [7:0] n_data, n_cmd;
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
    n_drop = 0; n_wr = 0; n_data = e_data;
    if (rst) begin
      tq.delete();
      m_prev_v = 0; m_last = 8'h00; n_data = 8'h00;
      idle_from = cyc + 1; rd_at = -1; err_at = -1; cmd_from = -1; cmd_to = -2;
    end else begin
      cap = game_valid && (!m_prev_v || game_byte != m_last);
      m_prev_v = game_valid;
      if (cap) m_last = game_byte;
      can = !tx_full && !e_wr;
      if (cap && is_cmd(game_byte)) begin
        if (tq.size() < DEPTH || can) tq.push_back(game_byte);
        else n_drop = 1;
      end
      if (can && tq.size() > 0) begin
        n_data = tq.pop_front();
        n_wr   = 1;
      end
      if (cyc >= idle_from && !rx_empty) begin
        rd_at = cyc + 1;
        if (is_cmd(rx_data)) begin
          cmd_b = rx_data; cmd_from = cyc + 2; cmd_to = cyc + HOLD + 1;
          idle_from = cyc + HOLD + 4;
        end else begin
          err_at = cyc + 2; idle_from = cyc + 2;
        end
      end
    end
    n_rd  = (rd_at == cyc + 1);
    n_err = (err_at == cyc + 1);
    n_cmd = (cyc + 1 >= cmd_from && cyc + 1 <= cmd_to) ? cmd_b : 8'h00;

    @(posedge clk);
    if (e_rd && rxq.size() > 0) void'(rxq.pop_front());
    cyc++;
    e_wr = n_wr; e_data = n_data; e_drop = n_drop; e_rd = n_rd; e_err = n_err; e_cmd = n_cmd;
    #1;
    check("cmd_out", {24'h0, cmd_out}, {24'h0, e_cmd});
    check("tx_wr",   {31'h0, tx_wr},   {31'h0, e_wr});
    check("tx_data", {24'h0, tx_data}, {24'h0, e_data});
    check("rx_rd",   {31'h0, rx_rd},   {31'h0, e_rd});
    check("tx_drop", {31'h0, tx_drop}, {31'h0, e_drop});
    check("rx_err",  {31'h0, rx_err},  {31'h0, e_err});

    if (tx_wr === 1'b1) begin s_wr++; wr_data.push_back(tx_data); wr_cyc.push_back(cyc); end
    if (tx_drop === 1'b1) s_drop++;
    if (rx_rd === 1'b1) begin s_rd++; rd_cyc.push_back(cyc); end
    if (rx_err === 1'b1) begin s_err++; err_cyc.push_back(cyc); end
    if (cmd_out !== 8'h00) begin
      s_cmd_nz++;
      if (cmd_first < 0) cmd_first = cyc;
      cmd_last = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int         c0;
    logic [7:0] pick;
    logic [7:0] ovf_bytes [5];
    ovf_bytes = '{8'h30, 8'h31, 8'h32, 8'h30, 8'h31};

    rst = 1'b1; game_valid = 1'b0; game_byte = 8'h00; tx_full = 1'b0;
    rx_empty = 1'b1; rx_data = 8'h00;
    clear_stats();
    steps(3);
    check("rst_cmd_out", {24'h0, cmd_out}, 32'h0);
    check("rst_tx_wr",   {31'h0, tx_wr},   32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_rd",   {31'h0, rx_rd},   32'h0);
    check("rst_tx_drop", {31'h0, tx_drop}, 32'h0);
    check("rst_rx_err",  {31'h0, rx_err},  32'h0);
    rst = 1'b0;

    // Dedup: constant byte held for 10 cycles -> one write, next cycle.
    clear_stats(); c0 = cyc;
    game_valid = 1'b1; game_byte = 8'h30;
    steps(10);
    game_valid = 1'b0;
    steps(4);
    check("dedup_count", s_wr, 1);
    if (s_wr >= 1) begin
      check("dedup_data", {24'h0, wr_data[0]}, 32'h30);
      check("dedup_latency", wr_cyc[0] - c0, 1);
    end

    // Byte change while held: 30 captured at c0, 31 at c0+3, 55 ignored.
    clear_stats(); c0 = cyc;
    game_valid = 1'b1; game_byte = 8'h30; steps(3);
    game_byte = 8'h31; steps(3);
    game_byte = 8'h55; steps(3);
    game_valid = 1'b0; steps(4);
    check("change_count", s_wr, 2);
    if (s_wr >= 2) begin
      check("change_data0", {24'h0, wr_data[0]}, 32'h30);
      check("change_data1", {24'h0, wr_data[1]}, 32'h31);
      check("change_cyc0", wr_cyc[0] - c0, 1);
      check("change_cyc1", wr_cyc[1] - c0, 4);
    end

    // Overflow: five captures into a 4-deep queue while tx_full is high.
    clear_stats();
    tx_full = 1'b1; game_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin game_byte = ovf_bytes[i]; step(); end
    game_valid = 1'b0; steps(2);
    check("ovf_drop", s_drop, 1);
    check("ovf_no_wr", s_wr, 0);
    c0 = cyc; tx_full = 1'b0;
    steps(12);
    check("ovf_wr_count", s_wr, 4);
    if (s_wr == 4) begin
      check("ovf_first_wr", wr_cyc[0] - c0, 1);
      for (int i = 0; i < 4; i++) check("ovf_order", {24'h0, wr_data[i]}, {24'h0, ovf_bytes[i]});
      for (int i = 0; i < 3; i++) check("ovf_spacing", wr_cyc[i+1] - wr_cyc[i], 2);
    end

    // Repeated RX command: two 31s. Windows at c0+2..c0+17 and c0+22..c0+37.
    clear_stats(); c0 = cyc;
    rxq.push_back(8'h31); rxq.push_back(8'h31);
    steps(50);
    check("rep_rd_count", s_rd, 2);
    check("rep_cmd_cycles", s_cmd_nz, 2 * HOLD);
    check("rep_cmd_first", cmd_first - c0, 2);
    check("rep_cmd_last", cmd_last - c0, 2 * HOLD + 5);
    check("rep_err", s_err, 0);
    if (s_rd == 2) begin
      check("rep_rd0", rd_cyc[0] - c0, 1);
      check("rep_rd1", rd_cyc[1] - c0, HOLD + 5);
    end

    // Invalid RX byte.
    clear_stats(); c0 = cyc;
    rxq.push_back(8'h41);
    steps(8);
    check("inv_err_count", s_err, 1);
    if (s_err == 1) check("inv_err_cyc", err_cyc[0] - c0, 2);
    check("inv_cmd", s_cmd_nz, 0);

    // Reset in the 5th HOLD cycle with two bytes queued for TX.
    clear_stats(); c0 = cyc;
    tx_full = 1'b1; game_valid = 1'b1; game_byte = 8'h30;
    rxq.push_back(8'h32);
    step();
    game_byte = 8'h31; step();
    game_valid = 1'b0;
    while (cyc < c0 + 6) step();
    check("rsth_cmd_before", {24'h0, cmd_out}, 32'h32);
    rst = 1'b1; step();
    check("rsth_cmd_after", {24'h0, cmd_out}, 32'h0);
    rst = 1'b0; tx_full = 1'b0;
    clear_stats();
    steps(10);
    check("rsth_no_wr", s_wr, 0);
    check("rsth_no_cmd", s_cmd_nz, 0);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) game_valid = ~game_valid;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0:       game_byte = 8'h30;
          1:       game_byte = 8'h31;
          2:       game_byte = 8'h32;
          3:       game_byte = 8'h55;
          default: game_byte = 8'($urandom);
        endcase
      end
      tx_full = ($urandom_range(0, 3) == 0);
      if (rxq.size() < 3 && $urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       pick = 8'h30;
          1:       pick = 8'h31;
          2:       pick = 8'h32;
          default: pick = 8'($urandom);
        endcase
        rxq.push_back(pick);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
